seq_shift_add_mul: RTL and testbench
====================================

# seq_shift_add_mul

Sequential unsigned shift-and-add multiplier. Each cycle it forms one n×1 partial-product row (multiplicand ANDed with one multiplier bit, added to the running upper accumulator) and retires one multiplier bit. It is the controller and accumulator stage that consumes the n×1 multiplier row results. It turns the row into a full WIDTH×WIDTH multiply with a start/busy/done handshake. The row adder is internal, so the block is self-contained.

## Interface
- WIDTH, 4, operand width in bits (≥2); the product is 2·WIDTH bits.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- start  in  1  request; sampled on a rising clk edge in IDLE or DONE.
- a  in  WIDTH  multiplicand; captured when start is accepted.
- m  in  WIDTH  multiplier; captured when start is accepted.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse on completion.
- p  out  2·WIDTH  product register; updated only on completion and held until the next completion.

## Operation
- State machine, with transitions on the rising clk edge:
  - IDLE -> RUN on start; a goes to areg, acc = {WIDTH'b0, m}, cnt = 0.
  - RUN -> RUN while cnt < WIDTH-1; cnt increments.
  - RUN -> DONE when the step with cnt = WIDTH-1 executes. That same edge loads p from the final acc value.
  - DONE -> RUN if start is high (back-to-back accept, with a new capture as in IDLE). Otherwise DONE -> IDLE.
- RUN step, unsigned:
  - b = acc[0]; hi = acc[2W-1:W].
  - sum[W:0] = hi + (b ? areg : 0).
  - acc <= {sum, acc[W-1:1]}.
  - After WIDTH steps, acc = a·m exactly; no overflow is possible.
- start is ignored in RUN. The a and m inputs are don't-care outside the accept edge.
- Outputs are registered: busy = (state == RUN), done = (state == DONE).
- The reset value of every output is 0: busy = 0, done = 0, p = 0. State = IDLE, acc = 0, cnt = 0.
- Reset asserted mid-RUN aborts the operation. p returns to 0, no done is issued, and the first start after release begins a fresh operation.

## Timing
- If start is accepted at edge k, then:
  - busy is high from k through k+WIDTH.
  - done and the new p are visible after edge k+WIDTH.
  - done falls after edge k+WIDTH+1.
- Latency from start to done is WIDTH+1 edges. Throughput is one product per WIDTH+1 cycles when start is held high.
- p changes only on the edge that enters DONE.
- Simultaneous start and DONE: the new operation is accepted and busy rises on the next edge. The old p stays visible during the DONE cycle.

## Configuration
- The macro MUL_SIGNED_EN selects signed operation.
- Undefined (default): unsigned operation as described above.
- Defined: a and m are two's complement and p is the signed 2·WIDTH-bit product. The row adder changes as follows:
  - It sign-extends both terms: sum = {hi[W-1], hi} ± (b ? {areg[W-1], areg} : 0).
  - It adds on steps cnt = 0..WIDTH-2.
  - It subtracts on step cnt = WIDTH-1, which is the multiplier sign bit.
- Handshake, latency and reset behaviour are identical in both modes.

## Test plan
- Basic multiply: WIDTH=4, reset low then high, a=6, m=10, start for 1 cycle. Required: busy high for 4 cycles, then done for 1 cycle, p=8'h3C, and p still 8'h3C 3 cycles later.
- Extremes: a=15, m=15 gives p=8'hE1. a=0, m=9 gives p=0. a=11, m=1 gives p=8'h0B. Each completes with a 5-edge latency.
- start is pulsed again during RUN (a=3, m=3). Required: it is ignored, and the first result (6×10=8'h3C) completes on schedule.
- Back-to-back: start held high with a=3, m=5 and then a=7, m=2. Required: done on consecutive 5-cycle boundaries with p=8'h0F and then 8'h0E, with no IDLE gap.
- Reset mid-operation: reset pulled low two cycles into RUN. Required: busy=0, done=0, p=0 immediately; no done follows. A new start with a=2, m=2 then gives p=8'h04.
- With MUL_SIGNED_EN defined:
  - a=4'b1010 (−6), m=5 gives p=8'hE2 (−30).
  - a=−8, m=−8 gives p=8'h40.
  - a=7, m=−1 gives p=8'hF9.

Source files
------------

// File: rtl/seq_shift_add_mul_if.sv
// rtl/seq_shift_add_mul_if.sv - start/busy/done handshake and operand/product bus for seq_shift_add_mul
interface seq_shift_add_mul_if #(
  parameter int WIDTH = 4
) ();
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     m;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   p;

  modport master (
    output start, a, m,
    input  busy, done, p
  );

  modport slave (
    input  start, a, m,
    output busy, done, p
  );
endinterface

// File: rtl/seq_shift_add_mul.sv
// rtl/seq_shift_add_mul.sv - sequential shift-and-add WIDTHxWIDTH multiplier, one multiplier bit per cycle
// Define MUL_SIGNED_EN for two's complement operands and a signed product.
module seq_shift_add_mul #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  seq_shift_add_mul_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     areg, areg_nxt;
  logic [2*WIDTH-1:0]   acc, acc_nxt;
  logic [2*WIDTH-1:0]   p_q, p_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;

  logic [WIDTH-1:0]     hi;
  logic                 b;
  logic [WIDTH:0]       addend;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   step_acc;
  logic                 last_step;

  assign last_step = (cnt == CW'(WIDTH - 1));

  // One n x 1 row: conditionally add the multiplicand into the upper half, then shift right.
  always_comb begin
    hi = acc[2*WIDTH-1:WIDTH];
    b  = acc[0];
`ifdef MUL_SIGNED_EN
    addend = b ? {areg[WIDTH-1], areg} : '0;
    // The final row carries the multiplier sign bit, whose weight is negative.
    if (last_step)
      sum = {hi[WIDTH-1], hi} - addend;
    else
      sum = {hi[WIDTH-1], hi} + addend;
`else
    addend = b ? {1'b0, areg} : '0;
    sum    = {1'b0, hi} + addend;
`endif
    step_acc = {sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    areg_nxt  = areg;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    p_nxt     = p_q;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nxt = RUN;
          areg_nxt  = bus.a;
          acc_nxt   = {{WIDTH{1'b0}}, bus.m};
          cnt_nxt   = '0;
        end else if (state == DONE) begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        acc_nxt = step_acc;
        if (last_step) begin
          state_nxt = DONE;
          p_nxt     = step_acc;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      areg <= '0;
      acc  <= '0;
      cnt  <= '0;
      p_q  <= '0;
    end else begin
      areg <= areg_nxt;
      acc  <= acc_nxt;
      cnt  <= cnt_nxt;
      p_q  <= p_nxt;
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.p    = p_q;

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// tb/tb_seq_shift_add_mul.sv - self-checking bench for seq_shift_add_mul (table, corner sequences, random vs model)
module tb_seq_shift_add_mul;

  localparam int W = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [2*W-1:0] last_p;

  seq_shift_add_mul_if #(.WIDTH(W)) bus ();

  seq_shift_add_mul #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   m;
    logic [2*W-1:0] p;
    string          name;
  } vec_t;

  vec_t vecs[4];

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] m);
    longint pr;
`ifdef MUL_SIGNED_EN
    longint sa;
    longint sm;
    sa = longint'($signed(a));
    sm = longint'($signed(m));
    pr = sa * sm;
`else
    pr = longint'(a) * longint'(m);
`endif
    return pr[2*W-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Issue one operation and verify busy window, done pulse, latency and product hold.
  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] mi,
                        input logic [2*W-1:0] exp, input string name);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ai;
    bus.m     = mi;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.m     = W'($urandom);
    for (int j = 0; j < W; j++) begin
      check({name, " busy"}, 64'(bus.busy), 64'(1));
      check({name, " no early done"}, 64'(bus.done), 64'(0));
      check({name, " p held"}, 64'(bus.p), 64'(last_p));
      @(negedge clk);
    end
    check({name, " done"}, 64'(bus.done), 64'(1));
    check({name, " busy low at done"}, 64'(bus.busy), 64'(0));
    check({name, " p"}, 64'(bus.p), 64'(exp));
    last_p = exp;
    @(negedge clk);
    check({name, " done falls"}, 64'(bus.done), 64'(0));
    check({name, " p after done"}, 64'(bus.p), 64'(exp));
  endtask

  initial begin
    logic saw_done;
    logic [W-1:0] ra, rm;
    checks    = 0;
    failures  = 0;
    last_p    = '0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.m     = '0;

`ifdef MUL_SIGNED_EN
    vecs[0] = '{a: 4'b1010, m: 4'd5,    p: 8'hE2, name: "neg6x5"};
    vecs[1] = '{a: 4'b1000, m: 4'b1000, p: 8'h40, name: "neg8xneg8"};
    vecs[2] = '{a: 4'd7,    m: 4'b1111, p: 8'hF9, name: "7xneg1"};
    vecs[3] = '{a: 4'd3,    m: 4'd3,    p: 8'h09, name: "3x3"};
`else
    vecs[0] = '{a: 4'd15, m: 4'd15, p: 8'hE1, name: "15x15"};
    vecs[1] = '{a: 4'd0,  m: 4'd9,  p: 8'h00, name: "0x9"};
    vecs[2] = '{a: 4'd11, m: 4'd1,  p: 8'h0B, name: "11x1"};
    vecs[3] = '{a: 4'd6,  m: 4'd10, p: 8'h3C, name: "6x10"};
`endif

    repeat (2) @(negedge clk);
    check("reset busy", 64'(bus.busy), 64'(0));
    check("reset done", 64'(bus.done), 64'(0));
    check("reset p", 64'(bus.p), 64'(0));
    reset = 1'b1;

    run_op(4'd6, 4'd10, model(4'd6, 4'd10), "basic");
    repeat (3) @(negedge clk);
    check("basic p hold 3", 64'(bus.p), 64'(model(4'd6, 4'd10)));

    for (int i = 0; i < 4; i++)
      run_op(vecs[i].a, vecs[i].m, vecs[i].p, vecs[i].name);

    // start pulsed mid-RUN must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'd6; bus.m = 4'd10;
    @(negedge clk);
    bus.start = 1'b0;
    for (int j = 0; j < W; j++) begin
      check("ign busy", 64'(bus.busy), 64'(1));
      if (j == 2) begin bus.start = 1'b1; bus.a = 4'd3; bus.m = 4'd3; end
      if (j == 3) bus.start = 1'b0;
      @(negedge clk);
    end
    check("ign done", 64'(bus.done), 64'(1));
    check("ign p", 64'(bus.p), 64'(model(4'd6, 4'd10)));
    last_p = model(4'd6, 4'd10);
    @(negedge clk);
    check("ign no restart busy", 64'(bus.busy), 64'(0));
    check("ign done falls", 64'(bus.done), 64'(0));

    // back-to-back with start held high
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'd3; bus.m = 4'd5;
    @(negedge clk);
    bus.a = 4'd7; bus.m = 4'd2;
    for (int j = 0; j < W; j++) begin
      check("b2b first busy", 64'(bus.busy), 64'(1));
      @(negedge clk);
    end
    check("b2b first done", 64'(bus.done), 64'(1));
    check("b2b first p", 64'(bus.p), 64'(model(4'd3, 4'd5)));
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b no gap busy", 64'(bus.busy), 64'(1));
    check("b2b done single", 64'(bus.done), 64'(0));
    check("b2b old p kept", 64'(bus.p), 64'(model(4'd3, 4'd5)));
    for (int j = 1; j < W; j++) begin
      @(negedge clk);
      check("b2b second busy", 64'(bus.busy), 64'(1));
    end
    @(negedge clk);
    check("b2b second done", 64'(bus.done), 64'(1));
    check("b2b second p", 64'(bus.p), 64'(model(4'd7, 4'd2)));
    last_p = model(4'd7, 4'd2);
    @(negedge clk);
    check("b2b second done falls", 64'(bus.done), 64'(0));

    // reset two cycles into RUN
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'd5; bus.m = 4'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort busy", 64'(bus.busy), 64'(0));
    check("abort done", 64'(bus.done), 64'(0));
    check("abort p", 64'(bus.p), 64'(0));
    last_p = '0;
    @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    for (int j = 0; j < W + 4; j++) begin
      @(negedge clk);
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    check("abort no done", 64'(saw_done), 64'(0));
    run_op(4'd2, 4'd2, model(4'd2, 4'd2), "after abort");

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rm = W'($urandom);
      run_op(ra, rm, model(ra, rm), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
